// File: rtl/ad_dac_dma_pkg.sv
// ad_dac_dma_pkg: shared state encoding and constants for the DAC DMA source
package ad_dac_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] DUNF_MAX = 16'hffff;

endpackage

// File: rtl/ad_dac_dma_fifo.sv
// ad_dac_dma_fifo: single-clock FIFO with wrap-bit pointers and combinational head
module ad_dac_dma_fifo #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;

    assign head  = mem[rptr[ADDR_WIDTH-1:0]];
    assign empty = wptr == rptr;
    assign full  = wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH] &&
                   wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0];
    assign level = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end

endmodule

// File: rtl/ad_dac_dma_source.sv
// ad_dac_dma_source: prefilled FIFO feeding the DAC core, with underflow fill and end-of-transfer drain
module ad_dac_dma_source
    import ad_dac_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int PREFILL    = 8
) (
    input  logic                  dac_clk,
    input  logic                  dac_rst,
    input  logic                  dac_enable,
    input  logic                  dac_valid,
    output logic [DATA_WIDTH-1:0] dac_ddata,
    output logic                  dac_dunf,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic [15:0]           dunf_count
);

    state_t                state;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [DATA_WIDTH-1:0] head;
    logic [ADDR_WIDTH:0]   fill_next;

    assign s_axis_ready = (state == FILL || state == RUN) && !full;
    assign push         = s_axis_valid && s_axis_ready;
    assign pop          = (state == RUN || state == DRAIN) && dac_valid && !empty;
    assign flush        = !dac_enable || state == IDLE;
    assign fill_next    = fifo_level + (ADDR_WIDTH+1)'(push);

    ad_dac_dma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) i_fifo (
        .clk   (dac_clk),
        .rst   (dac_rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (s_axis_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge dac_clk) begin
        if (dac_rst || !dac_enable) begin
            state      <= IDLE;
            dac_ddata  <= '0;
            dac_dunf   <= 1'b0;
            dunf_count <= '0;
        end else begin
            case (state)
                IDLE: state <= FILL;
                FILL: begin
                    if (push && s_axis_last)
                        state <= DRAIN;
                    else if (fill_next >= (ADDR_WIDTH+1)'(PREFILL))
                        state <= RUN;
                end
                RUN: begin
                    if (dac_valid) begin
                        dac_ddata  <= empty ? '0 : head;
                        dac_dunf   <= empty;
                        dunf_count <= (empty && dunf_count != DUNF_MAX) ? dunf_count + 16'd1 : dunf_count;
                    end
                    if (push && s_axis_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (dac_valid) begin
                        dac_ddata <= empty ? '0 : head;
                        dac_dunf  <= 1'b0;
                    end
                    if (empty || (pop && fifo_level == (ADDR_WIDTH+1)'(1)))
                        state <= DONE;
                end
                DONE: begin
                    if (dac_valid) begin
                        dac_ddata <= '0;
                        dac_dunf  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_dac_dma_source.sv
// tb_ad_dac_dma_source: queue-based reference model with a scoreboard monitor
module tb_ad_dac_dma_source;

    localparam int DW    = 256;
    localparam int AW    = 4;
    localparam int PF    = 8;
    localparam int DEPTH = 16;

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic          dac_clk = 1'b0;
    logic          dac_rst = 1'b0;
    logic          dac_enable = 1'b0;
    logic          dac_valid = 1'b0;
    logic [DW-1:0] dac_ddata;
    logic          dac_dunf;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_last = 1'b0;
    logic [AW:0]   fifo_level;
    logic [15:0]   dunf_count;

    ad_dac_dma_source #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PREFILL(PF)) dut (
        .dac_clk      (dac_clk),
        .dac_rst      (dac_rst),
        .dac_enable   (dac_enable),
        .dac_valid    (dac_valid),
        .dac_ddata    (dac_ddata),
        .dac_dunf     (dac_dunf),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .fifo_level   (fifo_level),
        .dunf_count   (dunf_count)
    );

    always #5 dac_clk = ~dac_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          dunf;
        int            level;
        int            cnt;
        logic          rdy;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mq[$];
    int            ph = P_IDLE;
    logic [DW-1:0] m_data = '0;
    logic          m_dunf = 1'b0;
    int            m_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++)
            v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock of stimulus; the model advances on the same edge and queues what the DUT should then show.
    task automatic cyc(input logic rst, input logic en, input logic dv, input logic sv,
                       input logic sl, input logic [DW-1:0] d, output logic acc);
        logic rdy;
        dac_rst      = rst;
        dac_enable   = en;
        dac_valid    = dv;
        s_axis_valid = sv;
        s_axis_last  = sl;
        s_axis_data  = d;
        rdy = (ph == P_FILL || ph == P_RUN) && mq.size() < DEPTH;
        acc = sv && rdy && !rst && en;
        @(posedge dac_clk);
        #1;
        if (rst || !en) begin
            ph = P_IDLE;
            mq.delete();
            m_data = '0;
            m_dunf = 1'b0;
            m_cnt  = 0;
        end else if (ph == P_IDLE) begin
            ph = P_FILL;
        end else if (ph == P_FILL) begin
            if (acc) mq.push_back(d);
            if (acc && sl) ph = P_DRAIN;
            else if (mq.size() >= PF) ph = P_RUN;
        end else if (ph == P_RUN) begin
            if (dv) begin
                if (mq.size() > 0) begin
                    m_data = mq.pop_front();
                    m_dunf = 1'b0;
                end else begin
                    m_data = '0;
                    m_dunf = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (acc) mq.push_back(d);
            if (acc && sl) ph = P_DRAIN;
        end else if (ph == P_DRAIN) begin
            if (dv) begin
                m_data = (mq.size() > 0) ? mq.pop_front() : '0;
                m_dunf = 1'b0;
            end
            if (mq.size() == 0) ph = P_DONE;
        end else if (dv) begin
            m_data = '0;
            m_dunf = 1'b0;
        end
        sb.push_back('{m_data, m_dunf, mq.size(), m_cnt,
                       (ph == P_FILL || ph == P_RUN) && mq.size() < DEPTH});
    endtask

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge dac_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ddata", dac_ddata, e.data);
                chk("dunf", DW'(dac_dunf), DW'(e.dunf));
                chk("level", DW'(fifo_level), DW'(e.level));
                chk("dunf_count", DW'(dunf_count), DW'(e.cnt));
                chk("ready", DW'(s_axis_ready), DW'(e.rdy));
            end
        end
    end

    initial begin
        logic acc;
        int   n;
        cyc(1, 0, 0, 0, 0, '0, acc);
        cyc(1, 0, 0, 0, 0, '0, acc);
        // prefill with dac_valid high, then underflow and recovery
        cyc(0, 1, 1, 0, 0, '0, acc);
        for (int i = 1; i <= 8; i++) cyc(0, 1, 1, 1, 0, DW'(i), acc);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, '0, acc);
        cyc(0, 1, 0, 1, 0, DW'(8'ha5), acc);
        cyc(0, 1, 1, 0, 0, '0, acc);
        cyc(0, 1, 0, 0, 0, '0, acc);
        // flush, then backpressure with data held until accepted
        cyc(0, 0, 0, 0, 0, '0, acc);
        cyc(0, 1, 0, 0, 0, '0, acc);
        n = 100;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 1, 0, DW'(n), acc);
            if (acc) n++;
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, 1, 0, DW'(n), acc);
            if (acc) n++;
        end
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, '0, acc);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, '0, acc);
        // enable drop mid-RUN, then restart
        cyc(0, 0, 1, 1, 0, DW'(999), acc);
        cyc(0, 1, 0, 0, 0, '0, acc);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 1, 0, DW'(200 + i), acc);
        cyc(0, 1, 1, 0, 0, '0, acc);
        // reset mid-RUN
        cyc(1, 1, 1, 1, 0, DW'(300), acc);
        cyc(0, 1, 1, 0, 0, '0, acc);
        // short transfer ending with last before prefill reached
        for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 1, i == 5, DW'(16'h50 + i), acc);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, '0, acc);
        cyc(0, 0, 0, 0, 0, '0, acc);
        // randomized traffic
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 79) != 0, $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, rnd_beat(), acc);
        @(negedge dac_clk);
        @(negedge dac_clk);
        chk("scoreboard_drained", DW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
